// File: rtl/sift_pkg.sv
// sift_pkg: shared keypoint geometry, stream word tags, streamer FSM states and word packing
package sift_pkg;
  localparam int ROWS = 480;
  localparam int COLS = 640;
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int KP_W = ROW_W + COL_W;
  localparam int KP_AW = 11;
  localparam int NUM_W = 12;
  localparam logic TAG_HDR = 1'b1;
  localparam logic [1:0] TAG_ROW = 2'b00;
  localparam logic [1:0] TAG_COL = 2'b01;
  localparam logic [15:0] WORD_END = 16'hFFFF;
  typedef enum logic [3:0] {
    S_IDLE, S_HDR1, S_ROW1, S_COL1, S_HDR2, S_ROW2, S_COL2, S_END, S_DONE
  } state_e;
  function automatic logic [15:0] pack_word(state_e s, logic [NUM_W-1:0] num, logic [KP_W-1:0] kp);
    logic l;
    l = s inside {S_HDR2, S_ROW2, S_COL2};
    return s inside {S_HDR1, S_HDR2} ? {TAG_HDR, l, 2'b00, num} :
           s inside {S_ROW1, S_ROW2} ? {TAG_ROW, l, 4'b0, kp[COL_W +: ROW_W]} :
           s inside {S_COL1, S_COL2} ? {TAG_COL, l, 3'b0, kp[COL_W-1:0]} :
           s == S_END ? WORD_END : 16'h0;
  endfunction
endpackage

// File: rtl/kpt_out_streamer.sv
// kpt_out_streamer: serialises keypoint memories 1/2 as HDR/ROW/COL/END words (start/nums in, rd_addr out, rd_data in, out_valid/out_data/busy/done out)
module kpt_out_streamer
  import sift_pkg::*;
#(
  parameter int KP_AW = sift_pkg::KP_AW,
  parameter int KP_W = sift_pkg::KP_W,
  parameter int NUM_W = sift_pkg::NUM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] kp1_num,
  input  logic [NUM_W-1:0] kp2_num,
  output logic [KP_AW-1:0] kp1_rd_addr,
  input  logic [KP_W-1:0]  kp1_rd_data,
  output logic [KP_AW-1:0] kp2_rd_addr,
  input  logic [KP_W-1:0]  kp2_rd_data,
  output logic             out_valid,
  output logic [15:0]      out_data,
  output logic             busy,
  output logic             done
);
  localparam logic [NUM_W-1:0] MAX_N = NUM_W'(2 ** KP_AW);
  state_e state_q, state_d;
  logic [NUM_W-1:0] n1_q, n1_d, n2_q, n2_d, cur_n, nxt_n;
  logic [KP_AW:0] idx_q, idx_d, idx_inc, idx_d_inc;
  logic [KP_AW-1:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic l2_cur, l2_nxt, last;
  assign l2_cur = state_q inside {S_ROW2, S_COL2};
  assign cur_n = l2_cur ? n2_q : n1_q;
  assign idx_inc = idx_q + 1'b1;
  assign last = idx_inc == (KP_AW+1)'(cur_n);
  always_comb begin
    state_d = state_q;
    n1_d = n1_q;
    n2_d = n2_q;
    idx_d = idx_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_HDR1;
        n1_d = kp1_num > MAX_N ? MAX_N : kp1_num;
        n2_d = kp2_num > MAX_N ? MAX_N : kp2_num;
      end
      S_HDR1: begin
        state_d = n1_q == '0 ? S_HDR2 : S_ROW1;
        idx_d = '0;
      end
      S_ROW1: state_d = S_COL1;
      S_COL1: begin
        state_d = last ? S_HDR2 : S_ROW1;
        idx_d = last ? '0 : idx_inc;
      end
      S_HDR2: begin
        state_d = n2_q == '0 ? S_END : S_ROW2;
        idx_d = '0;
      end
      S_ROW2: state_d = S_COL2;
      S_COL2: begin
        state_d = last ? S_END : S_ROW2;
        idx_d = last ? '0 : idx_inc;
      end
      S_END: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  // Address runs one entry ahead of the word being emitted so the registered
  // read data is ready when the next ROW is packed; it holds at the last entry.
  assign l2_nxt = state_d inside {S_HDR2, S_ROW2, S_COL2};
  assign nxt_n = l2_nxt ? n2_d : n1_d;
  assign idx_d_inc = idx_d + 1'b1;
  assign addr_d = state_d inside {S_ROW1, S_ROW2} ?
                    (idx_d_inc == (KP_AW+1)'(nxt_n) ? idx_d[KP_AW-1:0] : idx_d_inc[KP_AW-1:0]) :
                  state_d inside {S_COL1, S_COL2} ? addr_q : '0;
  assign data_d = pack_word(state_d, nxt_n, l2_nxt ? kp2_rd_data : kp1_rd_data);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n1_q <= '0;
      n2_q <= '0;
      idx_q <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      n1_q <= n1_d;
      n2_q <= n2_d;
      idx_q <= idx_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  assign busy = !(state_q inside {S_IDLE, S_DONE});
  assign out_valid = busy;
  assign out_data = data_q;
  assign done = state_q == S_DONE;
  assign kp1_rd_addr = state_q inside {S_ROW1, S_COL1} ? addr_q : '0;
  assign kp2_rd_addr = state_q inside {S_ROW2, S_COL2} ? addr_q : '0;
endmodule

// File: tb/tb_kpt_out_streamer.sv
// tb_kpt_out_streamer: scoreboard bench for kpt_out_streamer
module tb_kpt_out_streamer;
  localparam int KP_AW = 11;
  localparam int KP_W = 19;
  localparam int NUM_W = 12;
  logic clk = 0, rst_n = 0, start = 0;
  logic [NUM_W-1:0] kp1_num = '0, kp2_num = '0;
  logic [KP_AW-1:0] kp1_rd_addr, kp2_rd_addr;
  logic [KP_W-1:0] kp1_rd_data, kp2_rd_data;
  logic out_valid, busy, done;
  logic [15:0] out_data;
  logic [KP_W-1:0] mem1 [2048];
  logic [KP_W-1:0] mem2 [2048];
  logic [15:0] exp_q [$];
  int checks = 0, failures = 0;
  int n1e = 0, n2e = 0, max1 = 0, max2 = 0, viol = 0;
  kpt_out_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kp1_num(kp1_num), .kp2_num(kp2_num),
    .kp1_rd_addr(kp1_rd_addr), .kp1_rd_data(kp1_rd_data),
    .kp2_rd_addr(kp2_rd_addr), .kp2_rd_data(kp2_rd_data),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    kp1_rd_data <= mem1[kp1_rd_addr];
    kp2_rd_data <= mem2[kp2_rd_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) chk("extra_word", 32'(exp_q.size()), 1);
      else chk("word", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
    end
    if (busy) begin
      if (int'(kp1_rd_addr) > max1) max1 = int'(kp1_rd_addr);
      if (int'(kp2_rd_addr) > max2) max2 = int'(kp2_rd_addr);
      if ((kp1_rd_addr != 0 && int'(kp1_rd_addr) >= n1e) || (kp2_rd_addr != 0 && int'(kp2_rd_addr) >= n2e)) viol++;
    end
  end
  function automatic logic [KP_W-1:0] kp(input int r, input int c);
    return {r[8:0], c[9:0]};
  endfunction
  function automatic void fill();
    for (int i = 0; i < 2048; i++) begin
      mem1[i] = kp(i % 480, (i / 480) * 128 + $urandom_range(0, 127));
      mem2[i] = kp(479 - i % 480, (i / 480) * 128 + $urandom_range(0, 127));
    end
  endfunction
  function automatic logic [15:0] w_row(input int l, input logic [KP_W-1:0] e);
    return 16'(l << 13) | 16'(e >> 10);
  endfunction
  function automatic logic [15:0] w_col(input int l, input logic [KP_W-1:0] e);
    return 16'h4000 | 16'(l << 13) | 16'(e & 19'h3FF);
  endfunction
  task automatic run(input int k1, input int k2, input bit ghost, input int rst_at);
    int c, lim;
    n1e = k1 > 2048 ? 2048 : k1;
    n2e = k2 > 2048 ? 2048 : k2;
    max1 = 0; max2 = 0; viol = 0;
    exp_q.push_back(16'h8000 | 16'(n1e));
    for (int i = 0; i < n1e; i++) begin
      exp_q.push_back(w_row(0, mem1[i]));
      exp_q.push_back(w_col(0, mem1[i]));
    end
    exp_q.push_back(16'hC000 | 16'(n2e));
    for (int i = 0; i < n2e; i++) begin
      exp_q.push_back(w_row(1, mem2[i]));
      exp_q.push_back(w_col(1, mem2[i]));
    end
    exp_q.push_back(16'hFFFF);
    kp1_num = NUM_W'(k1);
    kp2_num = NUM_W'(k2);
    start = 1;
    @(negedge clk);
    start = 0;
    kp1_num = '0;
    kp2_num = '0;
    chk("busy_c1", busy, 1);
    c = 1;
    lim = 4 + 2 * (n1e + n2e) + 20;
    while (!done && c < lim) begin
      if (ghost && c == 3) start = 1;
      if (ghost && c == 4) start = 0;
      if (c == rst_at) begin
        #2 rst_n = 0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr1", kp1_rd_addr, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_idle", out_valid, 0);
        return;
      end
      @(negedge clk);
      c++;
    end
    chk("done_cyc", c, 4 + 2 * (n1e + n2e));
    chk("done_busy", busy, 0);
    chk("done_valid", out_valid, 0);
    chk("done_data", out_data, 0);
    if (ghost) start = 1;
    @(negedge clk);
    start = 0;
    chk("done_pulse", done, 0);
    repeat (2) @(negedge clk);
    chk("after_idle", {out_valid, busy}, 0);
    chk("q_left", exp_q.size(), 0);
    chk("max_addr1", max1, n1e == 0 ? 0 : n1e - 1);
    chk("max_addr2", max2, n2e == 0 ? 0 : n2e - 1);
    chk("addr_range", viol, 0);
  endtask
  initial begin
    fill();
    repeat (3) @(negedge clk);
    chk("reset_valid", out_valid, 0);
    chk("reset_data", out_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_addrs", {kp1_rd_addr, kp2_rd_addr}, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    run(0, 0, 0, 0);
    mem1[0] = kp(5, 7);
    mem1[1] = kp(479, 639);
    mem2[0] = kp(479, 639);
    run(2, 1, 0, 0);
    run(2, 1, 0, 5);
    run(2, 1, 0, 0);
    run(2, 1, 1, 0);
    fill();
    run(2048, 0, 0, 0);
    run(3000, 5, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
